// File: rtl/stream_fio_fifo.sv
// Single-clock stream FIFO with end-of-stream tracking and underrun/overflow status.
// The depth need not be a power of two, and sim_end freezes all state.
module stream_fio_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 101,
    parameter int HOLD_LAST = 1,
    localparam int LVL_W    = $clog2(DEPTH + 1),
    localparam int PTR_W    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sim_end,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_last,
    output logic             full,
    input  logic             rd_incadr,
    output logic [WIDTH-1:0] dout,
    output logic             data_empty,
    output logic [LVL_W-1:0] level,
    output logic [2:0]       fio_end
);

    typedef enum logic [1:0] {
        S_OPEN,
        S_CLOSED,
        S_EXHAUSTED,
        S_UNDERRUN
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [WIDTH-1:0] last_word;
    logic             overflow;
    logic             empty;
    logic             closed;
    logic             push;
    logic             pop;
    logic             drop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty  = (level == '0);
    assign full   = (level == LVL_W'(DEPTH));
    assign closed = (state != S_OPEN);
    assign push   = wr_en && !full && !closed && !sim_end;
    assign pop    = rd_incadr && !empty && !sim_end;
    assign drop   = wr_en && (full || closed) && !sim_end;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // A pop on an empty FIFO is ignored even when a push lands that same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            last_word  <= '0;
            data_empty <= 1'b0;
            overflow   <= 1'b0;
            state      <= S_OPEN;
        end else if (!sim_end) begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr    <= next_ptr(rd_ptr);
                last_word <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            if (rd_incadr) begin
                data_empty <= empty;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            case (state)
                S_OPEN:      if (wr_last)   state <= S_CLOSED;
                S_CLOSED:    if (empty)     state <= S_EXHAUSTED;
                S_EXHAUSTED: if (rd_incadr) state <= S_UNDERRUN;
                default:                    state <= state;
            endcase
        end
    end

    always_comb begin
        dout = '0;
        if (!empty) begin
            dout = mem[rd_ptr];
        end else if (HOLD_LAST != 0) begin
            dout = last_word;
        end
    end

    assign fio_end = {overflow,
                      state == S_UNDERRUN,
                      (state == S_EXHAUSTED) || (state == S_UNDERRUN)};

endmodule

// File: tb/tb_stream_fio_fifo.sv
// Drives two FIFO instances (DEPTH=4 holding last word, DEPTH=5 zeroing) with shared
// directed stimulus and checks both against a queue-style model plus literal expectations.
module tb_stream_fio_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       sim_end;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       wr_last;
    logic       rd_incadr;

    logic       full_a, full_b;
    logic [7:0] dout_a, dout_b;
    logic       de_a, de_b;
    logic [2:0] level_a, level_b;
    logic [2:0] fe_a, fe_b;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    stream_fio_fifo #(.WIDTH(8), .DEPTH(4), .HOLD_LAST(1)) dut_a (
        .clk(clk), .rst(rst), .sim_end(sim_end), .wr_en(wr_en), .wr_data(wr_data),
        .wr_last(wr_last), .full(full_a), .rd_incadr(rd_incadr), .dout(dout_a),
        .data_empty(de_a), .level(level_a), .fio_end(fe_a));

    stream_fio_fifo #(.WIDTH(8), .DEPTH(5), .HOLD_LAST(0)) dut_b (
        .clk(clk), .rst(rst), .sim_end(sim_end), .wr_en(wr_en), .wr_data(wr_data),
        .wr_last(wr_last), .full(full_b), .rd_incadr(rd_incadr), .dout(dout_b),
        .data_empty(de_b), .level(level_b), .fio_end(fe_b));

    // Model: index 0 mirrors dut_a, index 1 mirrors dut_b; m_data[i][0] is the head word.
    logic [7:0] m_data [2][8];
    int         m_count [2];
    logic [7:0] m_last [2];
    logic       m_dempty [2];
    logic       m_ovf [2];
    logic       m_closed [2];
    logic       m_exh [2];
    logic       m_under [2];
    bit         m_e, m_f, m_push, m_pop, m_was_exh;

    function automatic int depthOf(input int i);
        return (i == 0) ? 4 : 5;
    endfunction

    always @(posedge clk or negedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                m_count[i]  = 0;
                m_last[i]   = 8'd0;
                m_dempty[i] = 1'b0;
                m_ovf[i]    = 1'b0;
                m_closed[i] = 1'b0;
                m_exh[i]    = 1'b0;
                m_under[i]  = 1'b0;
            end else if (!sim_end) begin
                m_e       = (m_count[i] == 0);
                m_f       = (m_count[i] == depthOf(i));
                m_push    = wr_en && !m_f && !m_closed[i];
                m_pop     = rd_incadr && !m_e;
                m_was_exh = m_exh[i];
                if (wr_en && (m_f || m_closed[i])) m_ovf[i] = 1'b1;
                if (rd_incadr) m_dempty[i] = m_e;
                if (m_pop) begin
                    m_last[i] = m_data[i][0];
                    for (int k = 0; k < 7; k++) m_data[i][k] = m_data[i][k+1];
                    m_count[i]--;
                end
                if (m_push) begin
                    m_data[i][m_count[i]] = wr_data;
                    m_count[i]++;
                end
                if (m_closed[i] && !m_was_exh && m_e) m_exh[i] = 1'b1;
                if (m_was_exh && rd_incadr) m_under[i] = 1'b1;
                if (wr_last) m_closed[i] = 1'b1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkDut(input int i, input logic f, input logic [2:0] lv,
                            input logic [7:0] d, input logic de, input logic [2:0] fe);
        logic [7:0] exp_d;
        if (m_count[i] > 0)  exp_d = m_data[i][0];
        else if (i == 0)     exp_d = m_last[i];
        else                 exp_d = 8'd0;
        checkOutput($sformatf("model_full%0d", i), 64'(f), 64'(m_count[i] == depthOf(i)));
        checkOutput($sformatf("model_level%0d", i), 64'(lv), 64'(m_count[i]));
        checkOutput($sformatf("model_dout%0d", i), 64'(d), 64'(exp_d));
        checkOutput($sformatf("model_dempty%0d", i), 64'(de), 64'(m_dempty[i]));
        checkOutput($sformatf("model_fio_end%0d", i), 64'(fe),
                    64'({m_ovf[i], m_under[i], m_exh[i]}));
    endtask

    always @(negedge clk) begin
        if ($time > 10) begin
            checkDut(0, full_a, level_a, dout_a, de_a, fe_a);
            checkDut(1, full_b, level_b, dout_b, de_b, fe_b);
        end
    end

    task automatic applyStimulus(input logic we, input logic [7:0] d, input logic wl,
                                 input logic rd, input logic se);
        wr_en     = we;
        wr_data   = d;
        wr_last   = wl;
        rd_incadr = rd;
        sim_end   = se;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        wr_en = 0; wr_last = 0; rd_incadr = 0; sim_end = 0;
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_rst_level", 64'(level_a), 64'd0);
        checkOutput("async_rst_fio_end", 64'(fe_a), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; sim_end = 0; wr_en = 0; wr_data = 0; wr_last = 0; rd_incadr = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("rst_level", 64'(level_a), 64'd0);
        checkOutput("rst_full", 64'(full_a), 64'd0);
        checkOutput("rst_fio_end", 64'(fe_a), 64'd0);
        checkOutput("rst_dout", 64'(dout_a), 64'd0);
        checkOutput("rst_dempty", 64'(de_b), 64'd0);
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);

        // Fill the 4-deep instance, then overflow it.
        for (int k = 1; k <= 4; k++) applyStimulus(1, 8'(k * 10), 0, 0, 0);
        checkOutput("fill_full_a", 64'(full_a), 64'd1);
        checkOutput("fill_level_a", 64'(level_a), 64'd4);
        checkOutput("fill_level_b", 64'(level_b), 64'd4);
        checkOutput("fill_head_a", 64'(dout_a), 64'd10);
        applyStimulus(1, 8'd50, 0, 0, 0);
        checkOutput("ovf_fio_end_a", 64'(fe_a), 64'b100);
        checkOutput("ovf_level_a", 64'(level_a), 64'd4);
        checkOutput("ovf_fio_end_b", 64'(fe_b), 64'b000);
        checkOutput("ovf_full_b", 64'(full_b), 64'd1);
        for (int k = 1; k <= 4; k++) begin
            checkOutput($sformatf("pop_order_%0d", k), 64'(dout_a), 64'(k * 10));
            applyStimulus(0, 0, 0, 1, 0);
        end
        checkOutput("hold_last_a", 64'(dout_a), 64'd40);
        checkOutput("remain_b", 64'(dout_b), 64'd50);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("empty_pop_dempty_a", 64'(de_a), 64'd1);
        checkOutput("last_pop_dempty_b", 64'(de_b), 64'd0);
        checkOutput("zero_dout_b", 64'(dout_b), 64'd0);

        doReset();
        applyStimulus(1, 8'd7, 0, 1, 0);
        checkOutput("pushpop_empty_dempty", 64'(de_a), 64'd1);
        checkOutput("pushpop_empty_dout", 64'(dout_a), 64'd7);
        checkOutput("pushpop_empty_level", 64'(level_b), 64'd1);
        applyStimulus(0, 0, 0, 1, 0);

        // Streaming through with three words in flight forces pointer wrap.
        for (int k = 1; k <= 3; k++) applyStimulus(1, 8'(k), 0, 0, 0);
        for (int k = 0; k < 12; k++) applyStimulus(1, 8'(100 + k), 0, 1, 0);
        checkOutput("wrap_level_b", 64'(level_b), 64'd3);
        checkOutput("wrap_head_b", 64'(dout_b), 64'd109);
        checkOutput("wrap_fio_end_a", 64'(fe_a), 64'd0);
        for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 1, 0);

        doReset();
        applyStimulus(1, 8'd3, 1, 0, 0);
        checkOutput("close_level", 64'(level_a), 64'd1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("close_hold_a", 64'(dout_a), 64'd3);
        checkOutput("close_zero_b", 64'(dout_b), 64'd0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("exhausted_a", 64'(fe_a), 64'b001);
        checkOutput("exhausted_b", 64'(fe_b), 64'b001);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("underrun_a", 64'(fe_a), 64'b011);
        checkOutput("underrun_dempty", 64'(de_a), 64'd1);
        applyStimulus(1, 8'd9, 0, 0, 0);
        checkOutput("late_write_a", 64'(fe_a), 64'b111);

        doReset();
        for (int k = 1; k <= 3; k++) applyStimulus(1, 8'(k), 0, 0, 0);
        for (int k = 0; k < 5; k++) applyStimulus(1, 8'd55, 0, 1, 1);
        checkOutput("freeze_level", 64'(level_a), 64'd3);
        checkOutput("freeze_dout", 64'(dout_a), 64'd1);
        checkOutput("freeze_dempty", 64'(de_a), 64'd0);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midrun_rst_level", 64'(level_a), 64'd0);
        checkOutput("midrun_rst_fio_end", 64'(fe_b), 64'd0);
        checkOutput("midrun_rst_dout", 64'(dout_a), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        applyStimulus(1, 8'd77, 0, 0, 0);
        checkOutput("after_rst_dout", 64'(dout_a), 64'd77);
        checkOutput("after_rst_level", 64'(level_b), 64'd1);
        applyStimulus(0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stream_fio_fifo.md
STREAM_FIO_FIFO -- requirements
Module: stream_fio_fifo

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, data word width in bits (1..64).
REQ-002 SHALL provide parameter DEPTH, default 101, number of storage entries (2..1024, need not be a power of two).
REQ-003 SHALL provide parameter HOLD_LAST, default 1, empty-read mode: 1 = dout holds last popped word, 0 = dout drives all-zero.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low.
REQ-006 sim_end  input  1  end-of-simulation freeze.
REQ-007 wr_en  input  1  producer push request.
REQ-008 wr_data  input  WIDTH  push word.
REQ-009 wr_last  input  1  end-of-stream marker; may accompany a push or stand alone.
REQ-010 full  output  1  no free entry.
REQ-011 rd_incadr  input  1  consumer pop request.
REQ-012 dout  output  WIDTH  head word (combinational from storage).
REQ-013 data_empty  output  1  registered: last pop attempt found FIFO empty.
REQ-014 level  output  clog2(DEPTH+1)  current occupancy.
REQ-015 fio_end  output  3  status: [0] exhausted, [1] underrun, [2] overflow/late write.

Function
REQ-016 Push SHALL be accepted when wr_en=1, full=0, stream not closed and sim_end=0; word stored at wr_ptr, wr_ptr advances modulo DEPTH.
REQ-017 Pop SHALL occur when rd_incadr=1, empty=0 and sim_end=0; rd_ptr advances modulo DEPTH.
REQ-018 Pop and push in the same cycle SHALL both take effect whenever each is individually legal; level unchanged.
REQ-019 Pop while empty SHALL be ignored even if a push is accepted that cycle (written word becomes visible next cycle).
REQ-020 Push while full SHALL be dropped even if a pop occurs that cycle; fio_end[2] sets.
REQ-021 Pointer wrap SHALL go DEPTH-1 -> 0 with no gap; full when level==DEPTH, empty when level==0.
REQ-022 dout SHALL equal storage[rd_ptr] when not empty; when empty, last popped word (HOLD_LAST=1, all-zero before first pop) or zero (HOLD_LAST=0).
REQ-023 data_empty SHALL update only on cycles with rd_incadr=1: 1 if empty that cycle, else 0.
REQ-024 wr_last=1 SHALL close the stream after that cycle's push (if any); further wr_en SHALL be dropped and set fio_end[2].
REQ-025 Status states: OPEN -> CLOSED on wr_last; CLOSED -> EXHAUSTED when closed and level==0 (combinational check, registered next edge); EXHAUSTED -> UNDERRUN on first rd_incadr=1 in EXHAUSTED; UNDERRUN terminal until reset.
REQ-026 fio_end[0] SHALL be 1 in EXHAUSTED and UNDERRUN; fio_end[1] SHALL be 1 in UNDERRUN only; fio_end[2] sticky until reset.
REQ-027 sim_end=1 SHALL freeze pointers, storage, level, data_empty and fio_end at current values; deassertion resumes.
REQ-028 level SHALL increment on push-only, decrement on pop-only, hold otherwise; never exceed DEPTH.

Reset
REQ-029 rst=0 SHALL immediately clear pointers, level, data_empty, fio_end=000, last-word register (zero), state to OPEN; full=0.
REQ-030 Storage contents need not be reset; dout SHALL read zero while empty after reset.
REQ-031 Reset mid-stream SHALL discard all queued words; first push after rst release lands at entry 0.

Verification
REQ-032 DEPTH=4: push 10,20,30,40 -> full=1, level=4; fifth push 50 dropped, fio_end=100; pops return 10,20,30,40.
REQ-033 DEPTH=5: 12 push/pop pairs interleaved -> dout order preserved across wrap, level never >5, no drops.
REQ-034 Empty FIFO, push 7 and pop same cycle -> pop ignored, data_empty=1, next cycle dout=7, level=1.
REQ-035 Push 3 with wr_last, pop once -> dout 3 then holds 3 (HOLD_LAST=1), fio_end=001; extra rd_incadr -> fio_end=011, data_empty=1.
REQ-036 HOLD_LAST=0, same as REQ-035 -> dout=0 after last pop.
REQ-037 Three words queued, sim_end=1 with rd_incadr=1 for 5 cycles -> level stays 3, dout unchanged; rst=0 mid-run -> level=0, fio_end=000 asynchronously.
